// File: rtl/cmp_minmax_tracker.sv
// Streaming min/max tracker: consumes a packet of samples over valid/ready and
// presents min, max, their first-occurrence indices and the sample count as one result beat.
module cmp_minmax_tracker #(
   parameter int n    = 8,
   parameter bit sign = 1'b0,
   parameter int IW   = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [n-1:0]  in_data_i,
   input  logic          in_last_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [n-1:0]  min_o,
   output logic [n-1:0]  max_o,
   output logic [IW-1:0] min_idx_o,
   output logic [IW-1:0] max_idx_o,
   output logic [IW-1:0] count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0]    CODE_EQ = 2'b00;
   localparam logic [1:0]    CODE_LT = 2'b01;
   localparam logic [1:0]    CODE_GT = 2'b10;
   localparam logic [IW-1:0] CNT_MAX = '1;

   // Same code as the upstream compare stage: 00 equal, 01 a<b, 10 a>b.
   function automatic logic [1:0] cmp(input logic [n-1:0] a, input logic [n-1:0] b);
      logic lt;
      logic gt;
      if (sign) begin
         lt = $signed(a) < $signed(b);
         gt = $signed(a) > $signed(b);
      end else begin
         lt = a < b;
         gt = a > b;
      end
      if (lt)      return CODE_LT;
      else if (gt) return CODE_GT;
      else         return CODE_EQ;
   endfunction

   state_t        state_q, state_d;
   logic [n-1:0]  min_q, max_q;
   logic [IW-1:0] min_idx_q, max_idx_q, count_q;
   logic [1:0]    code_min, code_max;
   logic          in_fire;

   assign in_ready_o  = (state_q != DONE);
   assign out_valid_o = (state_q == DONE);
   assign in_fire     = in_valid_i & in_ready_o;

   always_comb begin
      code_min = cmp(in_data_i, min_q);
      code_max = cmp(in_data_i, max_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_fire) state_d = in_last_i ? DONE : ACCUM;
         end
         ACCUM: begin
            if (in_fire && in_last_i) state_d = DONE;
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // The index of a new sample is the count before increment; once the count
   // saturates, late samples are all recorded at the saturated index.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         count_q   <= '0;
      end else if (in_fire) begin
         if (state_q == IDLE) begin
            min_q     <= in_data_i;
            max_q     <= in_data_i;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= IW'(1);
         end else begin
            if (code_min == CODE_LT) begin
               min_q     <= in_data_i;
               min_idx_q <= count_q;
            end
            if (code_max == CODE_GT) begin
               max_q     <= in_data_i;
               max_idx_q <= count_q;
            end
            if (count_q != CNT_MAX) count_q <= count_q + IW'(1);
         end
      end
   end

   assign min_o     = min_q;
   assign max_o     = max_q;
   assign min_idx_o = min_idx_q;
   assign max_idx_o = max_idx_q;
   assign count_o   = count_q;

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Bench for cmp_minmax_tracker: three instances (unsigned, signed, IW=2) share one
// input stream; results are checked against a packet-level model through per-instance queues.
module tb_cmp_minmax_tracker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;

   logic       rdy0, rdy1, rdy2, ov0, ov1, ov2;
   logic [7:0] mn0, mx0, mi0, xi0, ct0;
   logic [7:0] mn1, mx1, mi1, xi1, ct1;
   logic [7:0] mn2, mx2;
   logic [1:0] mi2, xi2, ct2;

   int checks = 0;
   int failures = 0;

   logic [39:0] exp_q0[$];
   logic [39:0] exp_q1[$];
   logic [39:0] exp_q2[$];
   logic [7:0]  pkt[$];

   always #5 clk = ~clk;

   cmp_minmax_tracker #(.n(8), .sign(1'b0), .IW(8)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy0),
      .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(ov0), .out_ready_i(out_ready),
      .min_o(mn0), .max_o(mx0), .min_idx_o(mi0), .max_idx_o(xi0), .count_o(ct0));

   cmp_minmax_tracker #(.n(8), .sign(1'b1), .IW(8)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
      .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(ov1), .out_ready_i(out_ready),
      .min_o(mn1), .max_o(mx1), .min_idx_o(mi1), .max_idx_o(xi1), .count_o(ct1));

   cmp_minmax_tracker #(.n(8), .sign(1'b0), .IW(2)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy2),
      .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(ov2), .out_ready_i(out_ready),
      .min_o(mn2), .max_o(mx2), .min_idx_o(mi2), .max_idx_o(xi2), .count_o(ct2));

   function automatic logic [39:0] obs(input int k);
      case (k)
         0:       return {mn0, mx0, mi0, xi0, ct0};
         1:       return {mn1, mx1, mi1, xi1, ct1};
         default: return {mn2, mx2, 6'b0, mi2, 6'b0, xi2, 6'b0, ct2};
      endcase
   endfunction

   // Packet-level reference: first strict extreme wins, indices/count clip at 2**iw-1.
   function automatic logic [39:0] model(input bit sgn, input int iw);
      logic [7:0] mn, mx;
      int mi, xi, cap, cnt;
      cap = (1 << iw) - 1;
      mn = pkt[0];
      mx = pkt[0];
      mi = 0;
      xi = 0;
      for (int i = 1; i < pkt.size(); i++) begin
         if (sgn ? ($signed(pkt[i]) < $signed(mn)) : (pkt[i] < mn)) begin
            mn = pkt[i];
            mi = (i < cap) ? i : cap;
         end
         if (sgn ? ($signed(pkt[i]) > $signed(mx)) : (pkt[i] > mx)) begin
            mx = pkt[i];
            xi = (i < cap) ? i : cap;
         end
      end
      cnt = (pkt.size() < cap) ? pkt.size() : cap;
      return {mn, mx, mi[7:0], xi[7:0], cnt[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [39:0] o, input logic [39:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push_exp();
      exp_q0.push_back(model(1'b0, 8));
      exp_q1.push_back(model(1'b1, 8));
      exp_q2.push_back(model(1'b0, 2));
   endtask

   task automatic send_packet(input bit gaps);
      bit accepted;
      push_exp();
      for (int i = 0; i < pkt.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
               tick();
            end
         end
         in_valid = 1'b1;
         in_data  = pkt[i];
         in_last  = (i == pkt.size() - 1);
         accepted = 1'b0;
         for (int c = 0; c < 20 && !accepted; c++) begin
            accepted = rdy0;
            tick();
         end
         if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout observed=0 expected=1");
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("latency_valid0", ov0, 1'b1);
      check("latency_valid1", ov1, 1'b1);
      check("latency_valid2", ov2, 1'b1);
   endtask

   task automatic collect();
      bit seen;
      seen = ov0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         seen = ov0;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL out_valid_timeout observed=0 expected=1");
      end
      out_ready = 1'b1;
      check("result0", obs(0), exp_q0.pop_front());
      check("result1", obs(1), exp_q1.pop_front());
      check("result2", obs(2), exp_q2.pop_front());
      tick();
      out_ready = 1'b0;
      check("drop_valid", ov0, 1'b0);
      check("ready_again", rdy0, 1'b1);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      for (int k = 0; k < 3; k++) check("reset_outputs", obs(k), 40'h0);
      check("reset_valid", {ov0, ov1, ov2}, 3'b000);
      check("reset_ready", {rdy0, rdy1, rdy2}, 3'b111);
      rst_n = 1'b1;
      tick();

      // Reset mid-ACCUM after 3 samples
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(20 + i);
         in_last  = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      check("accum_count", ct0, 8'd3);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_outputs", obs(0), 40'h0);
      check("midrst_valid", ov0, 1'b0);
      check("midrst_ready", rdy0, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      pkt = {8'd5};
      send_packet(1'b0);
      check("single_spec", obs(0), {8'd5, 8'd5, 8'd0, 8'd0, 8'd1});
      collect();

      // Unsigned packet with ties
      pkt = {8'd3, 8'd9, 8'd1, 8'd9, 8'd1};
      send_packet(1'b0);
      check("ties_spec", obs(0), {8'd1, 8'd9, 8'd2, 8'd1, 8'd5});
      collect();

      // Signed vs unsigned on the same stream
      pkt = {8'h7F, 8'h80, 8'h00};
      send_packet(1'b0);
      check("signed_spec", obs(1), {8'h80, 8'h7F, 8'd1, 8'd0, 8'd3});
      check("unsigned_spec", obs(0), {8'h00, 8'h80, 8'd2, 8'd1, 8'd3});
      collect();

      // Backpressure in DONE with a sample offered
      pkt = {8'd2, 8'd6};
      send_packet(1'b0);
      in_valid = 1'b1;
      in_data  = 8'h33;
      in_last  = 1'b1;
      for (int h = 0; h < 4; h++) begin
         check("bp_stable", obs(0), exp_q0[0]);
         check("bp_valid", ov0, 1'b1);
         check("bp_ready", rdy0, 1'b0);
         tick();
      end
      collect();
      check("bp_not_consumed", ct0, 8'd2);
      pkt = {8'h33};
      push_exp();
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("bp_first_accept", ov0, 1'b1);
      check("bp_first_spec", obs(0), {8'h33, 8'h33, 8'd0, 8'd0, 8'd1});
      collect();

      // Count/index saturation with IW=2
      pkt = {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd0};
      send_packet(1'b0);
      check("sat_spec", obs(2), {8'd0, 8'd4, 8'd3, 8'd0, 8'd3});
      collect();

      // Valid gaps give the same result as the gap-free run
      pkt = {8'd10, 8'd20};
      send_packet(1'b0);
      check("nogap_spec", obs(0), {8'd10, 8'd20, 8'd0, 8'd1, 8'd2});
      collect();
      send_packet(1'b1);
      check("gap_spec", obs(0), {8'd10, 8'd20, 8'd0, 8'd1, 8'd2});
      collect();

      // Random packets with gaps
      for (int p = 0; p < 8; p++) begin
         pkt = {};
         for (int i = 0; i < $urandom_range(1, 9); i++) pkt.push_back(8'($urandom_range(0, 255)));
         send_packet(1'($urandom));
         collect();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
